// File: rtl/credit_admit_pkg.sv
// Shared options for the credit admission block: default sizes, credit-width
// derivation and the lane packing helper.
`ifndef FIFO_DWIDTH
`define FIFO_DWIDTH 8
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 4
`endif

// Selects lane i of a flat vector packed as lane i at [(i+1)*w-1 : i*w].
`define CA_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package credit_admit_pkg;

  // One extra bit so the counter can hold DEPTH itself, not just DEPTH-1.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned DefWidth  = `FIFO_DWIDTH;
  localparam int unsigned DefDepth  = `FIFO_DEPTH;
  localparam int unsigned DefCntwid = cnt_width(DefDepth);

endpackage

// File: rtl/credit_admit_lane.sv
// One lane of credit admission: credit counter, registered packet and push strobe.
module credit_lane
  import credit_admit_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned CNTWID = cnt_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_vld_i,
  input  logic [WIDTH-1:0]  in_data_i,
  input  logic              pop_i,
  output logic              in_rdy_o,
  output logic              acc_o,
  output logic              push_o,
  output logic [WIDTH-1:0]  data_o,
  output logic [CNTWID-1:0] credit_o,
  output logic              err_o
);

  localparam logic [CNTWID-1:0] FullCredit = CNTWID'(DEPTH);

  logic [CNTWID-1:0] credit_q, credit_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              push_q, push_d;
  logic              err_q, err_d;

  assign in_rdy_o = (credit_q != '0);
  assign acc_o    = in_vld_i & in_rdy_o;

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    push_d   = acc_o;
    data_d   = acc_o ? in_data_i : data_q;
    if (acc_o && !pop_i) begin
      credit_d = credit_q - CNTWID'(1);
    end else if (!acc_o && pop_i) begin
      // A pop with every credit already home means the downstream lost count.
      if (credit_q == FullCredit) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + CNTWID'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= FullCredit;
      data_q   <= '0;
      push_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      data_q   <= data_d;
      push_q   <= push_d;
      err_q    <= err_d;
    end
  end

  assign push_o   = push_q;
  assign data_o   = data_q;
  assign credit_o = credit_q;
  assign err_o    = err_q;

endmodule

// File: rtl/credit_admit.sv
// Credit-based admission into per-lane downstream FIFOs, with one-shot tagging
// of a magic packet on lane 0.
module credit_admit
  import credit_admit_pkg::*;
#(
  parameter int unsigned NUM_REQS = 1,
  parameter int unsigned WIDTH    = `FIFO_DWIDTH,
  parameter int unsigned DEPTH    = `FIFO_DEPTH,
  parameter int unsigned CNTWID   = cnt_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQS-1:0]        in_vld,
  output logic [NUM_REQS-1:0]        in_rdy,
  input  logic [NUM_REQS*WIDTH-1:0]  flat_in_data,
  input  logic [NUM_REQS-1:0]        pop,
  input  logic                       arm,
  output logic [NUM_REQS-1:0]        push,
  output logic [NUM_REQS*WIDTH-1:0]  flat_data_in,
  output logic                       start,
  output logic [NUM_REQS*CNTWID-1:0] credits,
  output logic                       err
);

  logic [NUM_REQS-1:0] acc;
  logic [NUM_REQS-1:0] lane_err;

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    credit_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNTWID(CNTWID)
    ) u_lane (
      .clk_i    (clk),
      .rst_ni   (rst),
      .in_vld_i (in_vld[i]),
      .in_data_i(`CA_LANE(flat_in_data, i, WIDTH)),
      .pop_i    (pop[i]),
      .in_rdy_o (in_rdy[i]),
      .acc_o    (acc[i]),
      .push_o   (push[i]),
      .data_o   (`CA_LANE(flat_data_in, i, WIDTH)),
      .credit_o (`CA_LANE(credits, i, CNTWID)),
      .err_o    (lane_err[i])
    );
  end

  assign err = |lane_err;

  logic armed_q, armed_d;
  logic tagged_q, tagged_d;
  logic start_q, start_d;

  // Once a magic packet has been tagged, arm is ignored until the next reset.
  always_comb begin
    armed_d  = armed_q;
    tagged_d = tagged_q;
    start_d  = 1'b0;
    if (!tagged_q) begin
      if ((armed_q || arm) && acc[0]) begin
        start_d  = 1'b1;
        tagged_d = 1'b1;
        armed_d  = 1'b0;
      end else if (arm) begin
        armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q  <= 1'b0;
      tagged_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      armed_q  <= armed_d;
      tagged_q <= tagged_d;
      start_q  <= start_d;
    end
  end

  assign start = start_q;

endmodule

// File: tb/tb_credit_admit.sv
// Directed bench for credit_admit: expected pushes are queued by the stimulus
// and matched by an independent monitor on the falling clock edge.
module tb_credit_admit;

  localparam int unsigned NR = 2;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    in_vld;
  logic [NR-1:0]    in_rdy;
  logic [NR*W-1:0]  flat_in_data;
  logic [NR-1:0]    pop;
  logic             arm;
  logic [NR-1:0]    push;
  logic [NR*W-1:0]  flat_data_in;
  logic             start;
  logic [NR*CW-1:0] credits;
  logic             err;

  typedef struct {
    logic [7:0] data;
    logic       start;
  } exp_t;

  exp_t       exp0_q[$];
  logic [7:0] exp1_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  credit_admit #(
    .NUM_REQS(NR),
    .WIDTH   (W),
    .DEPTH   (D),
    .CNTWID  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .flat_in_data(flat_in_data),
    .pop         (pop),
    .arm         (arm),
    .push        (push),
    .flat_data_in(flat_data_in),
    .start       (start),
    .credits     (credits),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp0(input logic [7:0] d, input logic s);
    exp_t e;
    e.data  = d;
    e.start = s;
    exp0_q.push_back(e);
  endtask

  // Monitor: every observed push must match the head of its lane queue.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (push[0] === 1'b1) begin
        if (exp0_q.size() == 0) begin
          chk("lane0 unexpected push", {24'h0, flat_data_in[7:0]}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp0_q.pop_front();
          chk("lane0 push data", {24'h0, flat_data_in[7:0]}, {24'h0, e.data});
          chk("lane0 push start", {31'h0, start}, {31'h0, e.start});
        end
      end else if (start === 1'b1) begin
        chk("start without push", 32'h1, 32'h0);
      end
      if (push[1] === 1'b1) begin
        if (exp1_q.size() == 0) begin
          chk("lane1 unexpected push", {24'h0, flat_data_in[15:8]}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e1;
          e1 = exp1_q.pop_front();
          chk("lane1 push data", {24'h0, flat_data_in[15:8]}, {24'h0, e1});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    in_vld       = '0;
    flat_in_data = '0;
    pop          = '0;
    arm          = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset credits", {26'h0, credits}, {26'h0, 3'd4, 3'd4});
    chk("reset push", {30'h0, push}, 32'h0);
    chk("reset start", {31'h0, start}, 32'h0);
    chk("reset err", {31'h0, err}, 32'h0);
    chk("reset data", {16'h0, flat_data_in}, 32'h0);
    chk("reset in_rdy", {30'h0, in_rdy}, 32'h3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // Fill lane 0: only four of six offered packets are admitted.
    for (int i = 0; i < 4; i++) exp0(8'h10 + 8'(i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_vld[0]        = 1'b1;
      flat_in_data[7:0] = 8'h10 + 8'(i);
      tick();
    end
    in_vld = '0;
    chk("full in_rdy0", {31'h0, in_rdy[0]}, 32'h0);
    chk("full credits0", {29'h0, credits[2:0]}, 32'h0);

    // One pop returns exactly one credit.
    pop[0] = 1'b1;
    tick();
    pop[0] = 1'b0;
    chk("pop credits0", {29'h0, credits[2:0]}, 32'h1);
    chk("pop in_rdy0", {31'h0, in_rdy[0]}, 32'h1);
    in_vld[0] = 1'b1;
    flat_in_data[7:0] = 8'h20;
    exp0(8'h20, 1'b0);
    tick();
    in_vld[0] = 1'b0;
    chk("refill credits0", {29'h0, credits[2:0]}, 32'h0);
    chk("refill push latency", {31'h0, push[0]}, 32'h1);
    tick();

    // Same-cycle accept and pop at two credits.
    pop[0] = 1'b1;
    tick();
    tick();
    pop[0] = 1'b0;
    chk("two credits", {29'h0, credits[2:0]}, 32'h2);
    in_vld[0] = 1'b1;
    pop[0] = 1'b1;
    flat_in_data[7:0] = 8'h30;
    exp0(8'h30, 1'b0);
    tick();
    in_vld[0] = 1'b0;
    pop[0] = 1'b0;
    chk("acc+pop credits", {29'h0, credits[2:0]}, 32'h2);
    chk("acc+pop push", {31'h0, push[0]}, 32'h1);
    tick();

    // Magic tag: pulse arm, then two packets; a later arm is ignored.
    pop[0] = 1'b1;
    tick();
    tick();
    pop[0] = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    in_vld[0] = 1'b1;
    flat_in_data[7:0] = 8'hA5;
    exp0(8'hA5, 1'b1);
    tick();
    chk("magic start", {31'h0, start}, 32'h1);
    flat_in_data[7:0] = 8'h3C;
    exp0(8'h3C, 1'b0);
    tick();
    chk("post magic start", {31'h0, start}, 32'h0);
    in_vld[0] = 1'b0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    in_vld[0] = 1'b1;
    flat_in_data[7:0] = 8'h77;
    exp0(8'h77, 1'b0);
    tick();
    in_vld[0] = 1'b0;
    chk("rearm start", {31'h0, start}, 32'h0);
    tick();

    // Lane 1 runs independently of lane 0.
    in_vld[1] = 1'b1;
    flat_in_data[15:8] = 8'h5A;
    exp1_q.push_back(8'h5A);
    tick();
    in_vld[1] = 1'b0;
    chk("lane1 credits", {29'h0, credits[5:3]}, 32'h3);
    chk("lane0 credits kept", {29'h0, credits[2:0]}, 32'h1);
    tick();

    // Over-pop at full credit sets a sticky error.
    pop[0] = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("no err yet", {31'h0, err}, 32'h0);
    chk("credits back to full", {29'h0, credits[2:0]}, 32'h4);
    tick();
    pop[0] = 1'b0;
    chk("overpop err", {31'h0, err}, 32'h1);
    chk("overpop credits", {29'h0, credits[2:0]}, 32'h4);
    tick();
    chk("err sticky", {31'h0, err}, 32'h1);

    // Reset while a push is on the outputs drops it.
    in_vld[0] = 1'b1;
    flat_in_data[7:0] = 8'h99;
    tick();
    in_vld[0] = 1'b0;
    chk("pending push", {31'h0, push[0]}, 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("async push clear", {30'h0, push}, 32'h0);
    chk("async credits", {26'h0, credits}, {26'h0, 3'd4, 3'd4});
    chk("async err clear", {31'h0, err}, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    tick();

    // Arm in the same cycle as the accept tags that packet.
    arm = 1'b1;
    in_vld[0] = 1'b1;
    flat_in_data[7:0] = 8'hC3;
    exp0(8'hC3, 1'b1);
    tick();
    arm = 1'b0;
    in_vld[0] = 1'b0;
    chk("same-cycle arm start", {31'h0, start}, 32'h1);
    tick();
    tick();

    chk("lane0 queue drained", exp0_q.size(), 32'h0);
    chk("lane1 queue drained", exp1_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/credit_admit.md
CREDIT_ADMIT -- requirements
Module: credit_admit

Interface
REQ-001 Parameter NUM_REQS, default 1, number of requestor lanes; one downstream FIFO per lane.
REQ-002 Parameter WIDTH, default `FIFO_DWIDTH, packet width in bits.
REQ-003 Parameter DEPTH, default `FIFO_DEPTH, entries per downstream FIFO; credits per lane.
REQ-004 Parameter CNTWID, default $clog2(DEPTH)+1, credit counter width.
REQ-005 Ports: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 in_vld  input  NUM_REQS  source packet valid, per lane.
REQ-009 in_rdy  output  NUM_REQS  lane accepts a packet this cycle.
REQ-010 flat_in_data  input  NUM_REQS*WIDTH  lane i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-011 pop  input  NUM_REQS  downstream FIFO pop (arbiter grant); returns one credit.
REQ-012 arm  input  1  request tagging of the next lane-0 packet as the magic packet.
REQ-013 push  output  NUM_REQS  FIFO push, per lane.
REQ-014 flat_data_in  output  NUM_REQS*WIDTH  FIFO write data, same lane packing.
REQ-015 start  output  1  marks the lane-0 push that carries the magic packet.
REQ-016 credits  output  NUM_REQS*CNTWID  current credit count per lane.
REQ-017 err  output  1  sticky credit-overflow flag.

Function
REQ-018 Lane i accepts (acc[i]) when in_vld[i] & in_rdy[i].
REQ-019 in_rdy[i] = (credit[i] != 0), combinational from registered state only.
REQ-020 Accepted data is registered: push[i] and lane i of flat_data_in update one cycle after acceptance; latency 1.
REQ-021 push[i] is high for exactly one cycle per accepted packet; with no accept, push[i]=0 and lane i data holds its last value.
REQ-022 credit[i]_next = credit[i] - acc[i] + pop[i]; accept and pop in the same cycle leave credit unchanged.
REQ-023 credit[i] never exceeds DEPTH; a pop with credit[i]==DEPTH and no accept leaves credit at DEPTH and sets err.
REQ-024 At credit[i]==0, in_rdy[i]=0; an in_vld[i] is held off with no accept and no push, and a same-cycle pop restores in_rdy[i] the next cycle.
REQ-025 Because every FIFO push consumes a credit first, the downstream FIFO is never pushed while full; back-to-back accepts sustain one push per cycle.
REQ-026 Magic tag: a rising arm, or arm held high, sets armed=1 once; armed stays set until consumed.
REQ-027 While armed=1, the first lane-0 accept clears armed and asserts start in the same cycle as the resulting push[0]; start is high for that one cycle.
REQ-028 arm asserted in the same cycle as a lane-0 accept tags that accept.
REQ-029 After tagging, further arm is ignored; the magic packet is captured only once per reset.
REQ-030 Lanes are independent; no cross-lane ordering is imposed.

Reset
REQ-031 rst low asynchronously forces credit[i]=DEPTH, push=0, start=0, armed=0, err=0, and flat_data_in=0.
REQ-032 A reset mid-operation discards the registered packet; no push is emitted for it after release.
REQ-033 Outputs are valid from the first rising clk after rst deasserts.

Structure
REQ-034 The packing macro/function, CNTWID derivation and credit-width constants reside in the shared options package.
REQ-035 One sub-module, credit_lane, holds the counter, data register and push for one lane, generated NUM_REQS times; the tag logic sits at top level for lane 0 only.

Verification
REQ-036 Reset then hold in_vld[0]=1 with pop=0 and DEPTH=4 -> 4 pushes on consecutive cycles, in_rdy[0]=0 from cycle 4, credits=0.
REQ-037 At credits=0, pulse pop[0] once -> credits=1, in_rdy[0]=1 next cycle, one more push, then credits=0.
REQ-038 Simultaneous accept and pop at credits=2 -> credits stays 2 and push follows 1 cycle later.
REQ-039 Pulse arm, then send 0xA5 then 0x3C on lane 0 -> start high only with push of 0xA5; a second arm gives no further start.
REQ-040 Pop at credits=DEPTH with no accept -> err=1 and sticky, credits=DEPTH.
REQ-041 Assert rst low while push is pending -> push=0 immediately, credits=DEPTH, no push after release.
